pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
Multi-channel PWM generator; N channels share one period counter, each with its own double-buffered duty register.
- Duty writes land in a shadow register and are applied only at the period boundary, so outputs never glitch mid-period.
- Drives motor/LED/servo outputs from the control core.
- Provides a period-end strobe for software or DMA synchronisation.

Parameters:
CHANNELS_NUM, 4, number of PWM channels (1..32).
PERIOD_MAX, 254, last counter value; edge-aligned period = PERIOD_MAX+1 CE ticks.
BITS_NUM, $clog2(PERIOD_MAX+2), width of counter and duty values; must represent PERIOD_MAX+1 (100 %).
CH_BITS_NUM, $clog2(CHANNELS_NUM) (min 1), channel-select width.
ACT_STATE, 1, active output level (0 or 1).

Ports:
CLK  in  1  clock; all state changes on rising edge.
CLR_N  in  1  synchronous reset, active-low.
CE  in  1  count enable; counter and shadow-to-active load advance only when high.
WR_EN  in  1  duty write strobe, one write per cycle.
WR_CH  in  CH_BITS_NUM  target channel of the write.
WR_DUTY  in  BITS_NUM  new duty, in CE ticks of active level per period.
EN  in  CHANNELS_NUM  per-channel output enable.
MODE  in  1  0 = edge-aligned, 1 = center-aligned (see Optional Feature).
Q  out  CHANNELS_NUM  PWM outputs.
PERIOD_END  out  1  one-cycle pulse at each period boundary.

Behaviour:
Reset (CLR_N=0 at a rising edge):
- cnt=0, dir=up, all shadow and active duty = 0, PERIOD_END=0, mode_act=0.
- While CLR_N=0, every Q bit is held at ~ACT_STATE.
- Reset mid-period aborts the period; after release, counting restarts at 0.

Counter (edge-aligned), on CE=1:
- cnt < PERIOD_MAX -> cnt+1.
- cnt == PERIOD_MAX -> wrap to 0. This is the "boundary" tick.
- CE=0: cnt, active duties and mode frozen; writes still accepted.

Writes:
- WR_EN=1 and WR_CH < CHANNELS_NUM -> shadow[WR_CH] <= WR_DUTY.
- WR_CH >= CHANNELS_NUM -> ignored, no effect.

Load:
- On the boundary tick: active[i] <= shadow[i] for all i; mode_act <= MODE.
- A write in the same cycle as the boundary tick bypasses to active (the new value is used in the next period).
- A write at any other time takes effect from cnt=0 of the following period.
- Latency: a write in period k is visible in period k+1, never partially within period k.

Output, combinational from registered state:
- Q[i] = ACT_STATE when CLR_N=1, EN[i]=1, and (active[i] > cnt or active[i] >= PERIOD_MAX+1).
- Otherwise Q[i] = ~ACT_STATE.
- duty 0 -> constantly inactive; duty >= PERIOD_MAX+1 -> constantly active, with no one-tick dropout at the wrap.
- EN acts immediately and asynchronously to the period; it does not affect the counter or loads.

PERIOD_END:
- Registered; high for exactly one CLK cycle following each boundary tick, i.e. the first cycle with cnt=0.
- Held 0 while CE remains low.

Optional Feature:
Macro PWM_MULTI_CHANNEL_CENTER_EN.

Defined:
- mode_act=1 selects up/down counting: 0 -> PERIOD_MAX, then PERIOD_MAX-1 -> 0. Period = 2*PERIOD_MAX CE ticks.
- dir flips at each end; each end value is held for one tick only.
- Boundary tick = the tick where cnt goes 1 -> 0 while counting down (the bottom). Loads and PERIOD_END use this boundary.
- The compare rule is unchanged, so the active pulse is symmetric about the bottom.
- A MODE change takes effect only at a boundary; the counter restarts upward from 0.

Not defined:
- MODE is ignored and mode_act stays 0.
- Only edge-aligned logic is synthesised.

Test Plan:
(CHANNELS_NUM=4, PERIOD_MAX=9, BITS_NUM=4, ACT_STATE=1)
1. Reset: CLR_N=0 for 2 cycles, then CE=1, EN=4'hF -> Q=4'h0 during and after reset; PERIOD_END first pulses 10 cycles after release (cnt back to 0).
2. Mid-period write: at cnt=4 write ch0=3 -> Q[0] stays 0 for the rest of the period; thereafter Q[0] high for cnt 0..2 (3 of 10 cycles) every period.
3. Boundary cases: duties ch1=0, ch2=10, ch3=15 -> Q[1] constantly 0; Q[2] and Q[3] constantly 1 with no dip at the wrap. Write to WR_CH=5 (when CH_BITS_NUM widened) or any invalid channel is ignored.
4. Simultaneous write and wrap: write ch0=7 in the cnt=9 cycle -> the next period shows 7 high cycles. Writing ch0=2 then ch0=5 in one period -> only 5 is applied.
5. CE gating and EN: CE toggling 1/0 -> period 20 CLK cycles, ch0 duty 3 high for 6 cycles. Deasserting EN[0] mid-pulse -> Q[0]=0 in the same cycle; counter phase unchanged.
6. With PWM_MULTI_CHANNEL_CENTER_EN, MODE=1, ch0=4 -> after the boundary, period 18 ticks; Q[0] high for cnt<4 on both slopes (7 consecutive ticks centred on cnt=0); PERIOD_END once per 18 ticks.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// Control/output bundle for pwm_multi_channel: duty writes, enables, mode and PWM outputs.
interface pwm_multi_channel_if #(
  parameter int unsigned CHANNELS_NUM = 4,
  parameter int unsigned BITS_NUM     = 8,
  parameter int unsigned CH_BITS_NUM  = 2
);
  logic                    ce;
  logic                    wr_en;
  logic [CH_BITS_NUM-1:0]  wr_ch;
  logic [BITS_NUM-1:0]     wr_duty;
  logic [CHANNELS_NUM-1:0] en;
  logic                    mode;
  logic [CHANNELS_NUM-1:0] q;
  logic                    period_end;

  modport master (
    output ce, wr_en, wr_ch, wr_duty, en, mode,
    input  q, period_end
  );

  modport slave (
    input  ce, wr_en, wr_ch, wr_duty, en, mode,
    output q, period_end
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter, per-channel shadow/active duty registers.
// Duty writes are staged in shadow registers and copied to the active set at the
// period boundary, so a period never mixes old and new duty values.
// Optional center-aligned counting is built only when PWM_MULTI_CHANNEL_CENTER_EN is
// defined; otherwise only the edge-aligned counter exists and bus.mode is ignored.
module pwm_multi_channel #(
  parameter int unsigned CHANNELS_NUM = 4,
  parameter int unsigned PERIOD_MAX   = 254,
  parameter int unsigned BITS_NUM     = $clog2(PERIOD_MAX + 2),
  parameter int unsigned CH_BITS_NUM  = (CHANNELS_NUM > 1) ? $clog2(CHANNELS_NUM) : 1,
  parameter bit          ACT_STATE    = 1'b1
) (
  input logic                clk,
  input logic                clr_n,
  pwm_multi_channel_if.slave bus
);

  localparam logic [BITS_NUM-1:0] CntMax   = BITS_NUM'(PERIOD_MAX);
  localparam logic [BITS_NUM-1:0] DutyFull = BITS_NUM'(PERIOD_MAX + 1);

  logic [BITS_NUM-1:0]     cnt_q, cnt_d;
  logic [BITS_NUM-1:0]     shadow_q [CHANNELS_NUM];
  logic [BITS_NUM-1:0]     shadow_d [CHANNELS_NUM];
  logic [BITS_NUM-1:0]     active_q [CHANNELS_NUM];
  logic [BITS_NUM-1:0]     active_d [CHANNELS_NUM];
  logic                    period_end_q;
  logic                    boundary;
  logic                    wr_valid;
  logic [CHANNELS_NUM-1:0] q;

  // Writes to channels beyond CHANNELS_NUM are dropped
  assign wr_valid = bus.wr_en && (32'(bus.wr_ch) < CHANNELS_NUM);

  // The boundary is the CE tick on which the counter returns to 0
  assign boundary = bus.ce && (cnt_d == '0);

`ifdef PWM_MULTI_CHANNEL_CENTER_EN
  logic dir_q, dir_d;    // 1 = counting down
  logic mode_q, mode_d;  // mode in force for the current period

  // Next count: edge-aligned wrap, or up/down with each end held for one tick
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (bus.ce) begin
      if (mode_q) begin
        if (!dir_q && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Reaching 0 ends the down slope; the next period counts up again
          dir_d = (cnt_q != BITS_NUM'(1));
        end
      end else begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        dir_d = 1'b0;
      end
    end
  end

  // Mode changes only at a boundary
  assign mode_d = boundary ? bus.mode : mode_q;

  // Direction and mode registers
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      dir_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  // Next count: edge-aligned wrap at PERIOD_MAX
  always_comb begin
    cnt_d = cnt_q;
    if (bus.ce) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end
`endif

  // Shadow capture and boundary load; a write on the boundary tick bypasses into active
  always_comb begin
    for (int i = 0; i < int'(CHANNELS_NUM); i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_valid && (bus.wr_ch == CH_BITS_NUM'(i))) begin
        shadow_d[i] = bus.wr_duty;
      end
      active_d[i] = boundary ? shadow_d[i] : active_q[i];
    end
  end

  // Counter, duty registers and period-end strobe
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q        <= '0;
      period_end_q <= 1'b0;
      for (int i = 0; i < int'(CHANNELS_NUM); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      period_end_q <= boundary;
      for (int i = 0; i < int'(CHANNELS_NUM); i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  // Compare outputs; a full-scale duty overrides the compare so there is no dropout at the wrap
  always_comb begin
    q = '0;
    for (int i = 0; i < int'(CHANNELS_NUM); i++) begin
      if (clr_n && bus.en[i] && ((active_q[i] > cnt_q) || (active_q[i] >= DutyFull))) begin
        q[i] = ACT_STATE;
      end else begin
        q[i] = ~ACT_STATE;
      end
    end
  end

  assign bus.q          = q;
  assign bus.period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel (4 channels, PERIOD_MAX=9, 3-bit channel select).
// A reference model predicts Q/PERIOD_END after every edge into a scoreboard queue;
// directed counts over whole periods check the behaviour called out for each scenario.
module tb_pwm_multi_channel;

  localparam int Chn = 4;
  localparam int Pm  = 9;

  logic clk;
  logic clr_n;

  pwm_multi_channel_if #(.CHANNELS_NUM(Chn), .BITS_NUM(4), .CH_BITS_NUM(3)) bus ();

  pwm_multi_channel #(
    .CHANNELS_NUM(Chn),
    .PERIOD_MAX  (Pm),
    .BITS_NUM    (4),
    .CH_BITS_NUM (3),
    .ACT_STATE   (1'b1)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cnt = 0;
  bit m_dir = 1'b0;
  bit m_mode = 1'b0;
  bit m_pe = 1'b0;
  int m_shadow [Chn] = '{default: 0};
  int m_active [Chn] = '{default: 0};

  logic [4:0] sb [$];

  // Observation statistics
  int hi [Chn];
  int n_pe;
  int first_pe;
  int ncyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr_stats();
    for (int i = 0; i < Chn; i++) hi[i] = 0;
    n_pe = 0;
    first_pe = 0;
    ncyc = 0;
  endtask

  task automatic model_step();
    bit bnd;
    bnd = 1'b0;
    if (!clr_n) begin
      m_cnt = 0;
      m_dir = 1'b0;
      m_mode = 1'b0;
      for (int i = 0; i < Chn; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      if (bus.wr_en && (int'(bus.wr_ch) < Chn)) m_shadow[int'(bus.wr_ch)] = int'(bus.wr_duty);
      if (bus.ce) begin
        if (m_mode) begin
          if (!m_dir) begin
            if (m_cnt == Pm) begin
              m_cnt = Pm - 1;
              m_dir = 1'b1;
            end else begin
              m_cnt++;
            end
          end else begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_dir = 1'b0;
              bnd = 1'b1;
            end
          end
        end else if (m_cnt == Pm) begin
          m_cnt = 0;
          bnd = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      if (bnd) begin
        for (int i = 0; i < Chn; i++) m_active[i] = m_shadow[i];
`ifdef PWM_MULTI_CHANNEL_CENTER_EN
        m_mode = bus.mode;
`endif
      end
    end
    m_pe = bnd;
  endtask

  function automatic logic [3:0] q_model();
    logic [3:0] r;
    for (int i = 0; i < Chn; i++) begin
      r[i] = clr_n && bus.en[i] && ((m_active[i] > m_cnt) || (m_active[i] >= Pm + 1));
    end
    return r;
  endfunction

  // One clock: predict at the edge, compare on the falling edge
  task automatic cyc();
    logic [4:0] e;
    @(posedge clk);
    model_step();
    sb.push_back({m_pe, q_model()});
    @(negedge clk);
    e = sb.pop_front();
    chk("q", 32'(bus.q), 32'(e[3:0]));
    chk("period_end", 32'(bus.period_end), 32'(e[4]));
    ncyc++;
    for (int i = 0; i < Chn; i++) if (bus.q[i]) hi[i]++;
    if (bus.period_end) begin
      n_pe++;
      if (first_pe == 0) first_pe = ncyc;
    end
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while ((m_cnt != v) && (k < 40)) begin
      cyc();
      k++;
    end
    if (k >= 40) begin
      total++;
      bad++;
      $error("FAIL wait_cnt observed=timeout expected=cnt %0d", v);
    end
  endtask

  task automatic wait_pe();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!bus.period_end && (k < 40));
    if (!bus.period_end) begin
      total++;
      bad++;
      $error("FAIL wait_pe observed=no strobe expected=strobe within 40 cycles");
    end
  endtask

  task automatic write(input int ch, input int d);
    bus.wr_en = 1'b1;
    bus.wr_ch = 3'(ch);
    bus.wr_duty = 4'(d);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    bus.ce = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_duty = '0;
    bus.en = 4'hF;
    bus.mode = 1'b0;
    clr_stats();

    // 1. Reset: outputs inactive, first strobe 10 cycles after release
    #1;
    chk("q_before_edge", 32'(bus.q), 32'h0);
    cyc();
    cyc();
    chk("q_in_reset", 32'(bus.q), 32'h0);
    clr_n = 1'b1;
    clr_stats();
    repeat (12) cyc();
    chk("first_pe_after_reset", first_pe, 10);
    chk("q_after_reset", hi[0] + hi[1] + hi[2] + hi[3], 0);

    // 2. Mid-period write is deferred to the next period
    wait_cnt(4);
    clr_stats();
    write(0, 3);
    repeat (4) cyc();
    chk("midperiod_no_glitch", hi[0], 0);
    clr_stats();
    repeat (10) cyc();
    chk("duty3_high", hi[0], 3);
    chk("duty3_pe", n_pe, 1);

    // 3. Boundary duties and an out-of-range channel
    write(1, 0);
    write(2, 10);
    write(3, 15);
    write(5, 7);
    wait_pe();
    clr_stats();
    repeat (20) cyc();
    chk("duty0_never", hi[1], 0);
    chk("duty_full", hi[2], 20);
    chk("duty_over", hi[3], 20);
    chk("ch0_kept", hi[0], 6);
    chk("bnd_pe", n_pe, 2);

    // 4. Write on the wrap tick, and last write in a period wins
    wait_cnt(9);
    clr_stats();
    write(0, 7);
    repeat (9) cyc();
    chk("wrap_write", hi[0], 7);
    wait_cnt(3);
    write(0, 2);
    wait_cnt(6);
    write(0, 5);
    wait_pe();
    clr_stats();
    repeat (10) cyc();
    chk("last_write_wins", hi[0], 5);

    // 5. CE at half rate doubles the period
    write(0, 3);
    wait_pe();
    clr_stats();
    for (int j = 1; j <= 40; j++) begin
      bus.ce = (j % 2 == 0);
      cyc();
    end
    bus.ce = 1'b1;
    chk("ce_half_high", hi[0], 12);
    chk("ce_half_pe", n_pe, 2);

    // EN drops the output immediately without disturbing the counter
    wait_cnt(1);
    bus.en = 4'hE;
    #1;
    chk("en_immediate", 32'(bus.q[0]), 32'h0);
    clr_stats();
    repeat (9) cyc();
    chk("en_phase", first_pe, 9);
    bus.en = 4'hF;

    // Reset mid-period restarts the count and clears duties
    wait_cnt(5);
    clr_n = 1'b0;
    cyc();
    chk("q_mid_reset", 32'(bus.q), 32'h0);
    clr_n = 1'b1;
    clr_stats();
    repeat (12) cyc();
    chk("mid_reset_pe", first_pe, 10);
    chk("mid_reset_duty", hi[2], 0);

    // 6. Mode select
    bus.mode = 1'b1;
    write(0, 4);
    wait_pe();
    clr_stats();
`ifdef PWM_MULTI_CHANNEL_CENTER_EN
    repeat (36) cyc();
    chk("center_pe", n_pe, 2);
    chk("center_high", hi[0], 14);
`else
    repeat (20) cyc();
    chk("mode_ignored_pe", n_pe, 2);
    chk("mode_ignored_high", hi[0], 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
